// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared types and constants for the adder BIST engine
//
// Purpose : sequencer state encoding and error-counter sizing shared by
//           adder_bist and sat_counter.
// Ports   : none (package).
package adder_bist_pkg;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE_WAIT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/adder_bist_sat_counter.sv
// rtl/adder_bist_sat_counter.sv - saturating error counter with synchronous clear
//
// Purpose : ERR_W-bit up-counter that sticks at ERR_MAX instead of wrapping.
// Ports   : clk   - rising-edge clock
//           clr   - synchronous clear, wins over inc
//           inc   - count one event this cycle
//           count - current count
module sat_counter
  import adder_bist_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [ERR_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != ERR_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/adder_bist.sv
// rtl/adder_bist.sv - exhaustive built-in self test for an external adder
//
// Purpose : walks every {a,b} operand pair through an external adder, waits
//           SETTLE cycles per vector, compares against a local combinational
//           reference and reports pass/fail, a saturating mismatch count and
//           the first failing vector.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           start, abort        - begin an exhaustive run / cancel a run
//           dut_a, dut_b        - registered operands to the adder
//           dut_sum, dut_cout   - adder result
//           busy, done, pass    - run status (pass valid while done)
//           err_count           - saturating mismatch count
//           fail_a, fail_b      - first mismatching vector of the run
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int VEC_W = 2 * WIDTH;
  // Cycles spent in SETTLE_WAIT per vector; APPLY and CHECK take one each.
  localparam logic [3:0] WAIT_INIT = 4'(SETTLE - 1);

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [3:0]       wait_cnt;

  logic [WIDTH:0]   expected;
  logic             mismatch;
  logic             run_state;
  logic             start_ok;
  logic             abort_ok;
  logic             err_inc;
  logic             err_clr;

  // Reference model works on the registered operands, which are what the
  // adder has been seeing since APPLY.
  always_comb begin
    expected  = {1'b0, dut_a} + {1'b0, dut_b};
    mismatch  = ({dut_cout, dut_sum} != expected);
    run_state = (state == APPLY) || (state == SETTLE_WAIT) || (state == CHECK);
    start_ok  = start && ((state == IDLE) || (state == DONE));
    abort_ok  = abort && run_state;
    // An abort landing on the CHECK cycle discards that sample.
    err_inc   = (state == CHECK) && mismatch && !abort && !rst;
    err_clr   = rst || start_ok;
  end

  sat_counter u_err_count (
    .clk   (clk),
    .clr   (err_clr),
    .inc   (err_inc),
    .count (err_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= '0;
      wait_cnt <= '0;
      dut_a    <= '0;
      dut_b    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_a   <= '0;
      fail_b   <= '0;
    end else if (start_ok) begin
      state  <= APPLY;
      vec    <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
      pass   <= 1'b0;
      fail_a <= '0;
      fail_b <= '0;
    end else if (abort_ok) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        APPLY: begin
          dut_a    <= vec[VEC_W-1:WIDTH];
          dut_b    <= vec[WIDTH-1:0];
          wait_cnt <= WAIT_INIT;
          state    <= (WAIT_INIT == 4'd0) ? CHECK : SETTLE_WAIT;
        end
        SETTLE_WAIT: begin
          if (wait_cnt <= 4'd1) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        CHECK: begin
          // err_count is still zero only until the first mismatch of the run.
          if (mismatch && (err_count == '0)) begin
            fail_a <= dut_a;
            fail_b <= dut_b;
          end
          if (&vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            vec   <= vec + 1'b1;
            state <= APPLY;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width of the adder under test (1..6).
REQ-002 SHALL have parameter SETTLE, default 2, cycles from vector apply to result sample (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin an exhaustive run.
REQ-006 SHALL have port abort  input  1  cancels a run in progress.
REQ-007 SHALL have port dut_a  output  WIDTH  operand A driven to the adder.
REQ-008 SHALL have port dut_b  output  WIDTH  operand B driven to the adder.
REQ-009 SHALL have port dut_sum  input  WIDTH  sum returned by the adder.
REQ-010 SHALL have port dut_cout  input  1  carry returned by the adder.
REQ-011 SHALL have port busy  output  1  run in progress.
REQ-012 SHALL have port done  output  1  run completed; held until next start or reset.
REQ-013 SHALL have port pass  output  1  valid when done; 1 iff err_count == 0.
REQ-014 SHALL have port err_count  output  8  saturating mismatch count.
REQ-015 SHALL have port fail_a / fail_b  output  WIDTH each  first mismatching vector.

Function
REQ-016 SHALL implement states IDLE, APPLY, SETTLE_WAIT, CHECK, DONE.
REQ-017 SHALL, on start in IDLE or DONE, clear err_count, fail_a, fail_b, done, pass, set vector {a,b}=0, enter APPLY.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL register dut_a/dut_b in APPLY; hold them constant until the next APPLY.
REQ-020 SHALL sample dut_sum/dut_cout exactly SETTLE cycles after the vector is applied; each vector occupies SETTLE+1 cycles.
REQ-021 SHALL compute expected result as WIDTH+1-bit a+b; mismatch iff {dut_cout,dut_sum} differs.
REQ-022 SHALL increment err_count per mismatch, saturating at 255 (no wrap).
REQ-023 SHALL latch fail_a/fail_b on the first mismatch of a run only.
REQ-024 SHALL step vectors in order a-major: {a,b} increments as one 2*WIDTH-bit counter.
REQ-025 SHALL enter DONE after checking {a,b} = all ones, with no counter wrap; total busy cycles = 2^(2*WIDTH) * (SETTLE+1).
REQ-026 SHALL assert busy in APPLY, SETTLE_WAIT, CHECK; done and pass only in DONE.
REQ-027 SHALL, on abort while busy, return to IDLE next cycle, done=0, pass=0, err_count retained; abort in IDLE/DONE ignored.
REQ-028 SHALL give abort priority over a same-cycle CHECK result (that sample discarded).

Reset
REQ-029 SHALL, on rst high at a clock edge, enter IDLE with all outputs 0 (dut_a, dut_b, busy, done, pass, err_count, fail_a, fail_b), including mid-run.
REQ-030 SHALL give rst priority over start and abort.

Structure
REQ-031 SHALL place state enum and ERR_W=8 / ERR_MAX=255 constants in shared package adder_bist_pkg.
REQ-032 SHALL use one sub-module sat_counter (ERR_W-bit saturating increment, synchronous clear).
REQ-033 SHALL keep the expected-value model combinational inside adder_bist.

Verification
REQ-034 Correct adder model, WIDTH=4, SETTLE=2, start -> done after 768 busy cycles, pass=1, err_count=0.
REQ-035 Model with dut_cout stuck 0 -> err_count=120, fail_a=1, fail_b=15, pass=0.
REQ-036 Model with dut_sum inverted -> 256 mismatches, err_count=255 saturated, fail_a=0, fail_b=0.
REQ-037 Abort at busy cycle 100 -> IDLE next cycle, busy=0, done=0; restart then runs full 768 cycles.
REQ-038 rst at busy cycle 50 -> all outputs 0 next cycle; start during busy ignored; start in DONE clears counters and reruns.
